// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port no-change block RAM between the capture path (port A) and the
// host/readout path (port B). At most one access is granted per cycle. The RAM command is
// registered, and read data returns to its owner 1+RD_LATENCY cycles after the grant.
// A tag pipeline tracks which port owns each in-flight read.
// Build option: RAM_ARB_FIXED_PRIORITY_EN. When defined, A always wins a conflict and no
// round-robin state exists. When undefined (default), arbitration is round-robin.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned RD_LATENCY = 2    // 1 or 2
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_regcea,
  output logic              ram_rsta,
  input  logic [DATA_W-1:0] ram_douta
);

  // Stage 0 lines up with the RAM command cycle; the last stage lines up with valid data.
  localparam int unsigned PipeDepth = 1 + RD_LATENCY;

  logic                 ram_ena_q;
  logic                 ram_wea_q;
  logic [ADDR_W-1:0]    ram_addra_q;
  logic [DATA_W-1:0]    ram_dina_q;
  logic [PipeDepth-1:0] tag_a_q;
  logic [PipeDepth-1:0] tag_b_q;
  logic                 started_q;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: A wins every conflict
  always_comb begin
    a_gnt = rsta_n & a_req;
    b_gnt = rsta_n & b_req & ~a_req;
  end
`else
  logic last_b_q;  // 1 when B was granted most recently

  // Round-robin: on a conflict the port not granted most recently wins
  always_comb begin
    a_gnt = rsta_n & a_req & (~b_req | last_b_q);
    b_gnt = rsta_n & b_req & (~a_req | ~last_b_q);
  end

  // Remember the last winner; resets to B so A takes the first conflict
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      last_b_q <= 1'b1;
    end else if (a_gnt) begin
      last_b_q <= 1'b0;
    end else if (b_gnt) begin
      last_b_q <= 1'b1;
    end
  end
`endif

  // Register the granted command; with no grant only the enable drops
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ram_ena_q   <= 1'b0;
      ram_wea_q   <= 1'b0;
      ram_addra_q <= '0;
      ram_dina_q  <= '0;
    end else begin
      ram_ena_q <= a_gnt | b_gnt;
      if (a_gnt) begin
        ram_wea_q   <= a_we;
        ram_addra_q <= a_addr;
        ram_dina_q  <= a_wdata;
      end else if (b_gnt) begin
        ram_wea_q   <= b_we;
        ram_addra_q <= b_addr;
        ram_dina_q  <= b_wdata;
      end
    end
  end

  // Owner-tag pipeline: each granted read enters here; reset drops every in-flight tag
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      tag_a_q <= '0;
      tag_b_q <= '0;
    end else begin
      tag_a_q <= {tag_a_q[PipeDepth-2:0], a_gnt & ~a_we};
      tag_b_q <= {tag_b_q[PipeDepth-2:0], b_gnt & ~b_we};
    end
  end

  // Marks the first clock edge after reset release; ram_rsta is high until then
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  // Output register only needs enabling while a tracked read sits in the RAM read latch
  if (RD_LATENCY == 2) begin : g_regce
    assign ram_regcea = tag_a_q[1] | tag_b_q[1];
  end else begin : g_no_regce
    assign ram_regcea = 1'b0;
  end

  assign ram_ena   = ram_ena_q;
  assign ram_wea   = ram_wea_q;
  assign ram_addra = ram_addra_q;
  assign ram_dina  = ram_dina_q;
  // Sampled by the RAM at the first edge after release, which clears its output register
  assign ram_rsta  = rsta_n & ~started_q;

  assign a_rvalid = tag_a_q[PipeDepth-1];
  assign b_rvalid = tag_b_q[PipeDepth-1];
  // Both buses carry RAM data; consumers qualify with rvalid
  assign a_rdata  = rsta_n ? ram_douta : '0;
  assign b_rdata  = rsta_n ? ram_douta : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: behavioural RAM plus a transaction-level reference model.
module tb_ram_port_arbiter;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 18;
  localparam int unsigned RDL = 2;

  typedef struct {
    bit            is_b;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  logic          clka = 1'b0;
  logic          rsta_n;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_ena, ram_wea, ram_regcea, ram_rsta;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina, ram_douta;

  always #5 clka = ~clka;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_regcea(ram_regcea), .ram_rsta(ram_rsta), .ram_douta(ram_douta)
  );

  // Single-port no-change RAM with internal read latch and output register
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] ram_lat = '0;
  logic [DW-1:0] ram_out = '0;
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      else         ram_lat <= mem[ram_addra];
    end
    if (ram_rsta)        ram_out <= '0;
    else if (ram_regcea) ram_out <= ram_lat;
  end
  assign ram_douta = ram_out;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: memory contents, ordered response queue, last winner
  logic [DW-1:0] shadow [int];
  resp_t         resp_q [$];
  bit            last_b = 1'b1;
  bit            prev_gnt = 1'b0;
  int            cyc = 0;
  int            rel_cnt = 0;

  bit            e_agnt, e_bgnt, e_arv, e_brv, e_ena, e_rsta;
  logic [DW-1:0] e_data;
  logic          o_agnt, o_bgnt, o_arv, o_brv, o_ena, o_wea, o_regce, o_rsta;
  logic [DW-1:0] o_ardata, o_brdata, o_din;
  logic [AW-1:0] o_addr;

  // Advance one cycle: compute expectations, sample the DUT, commit accepted accesses
  task automatic tick();
    resp_t r;
    int    ad;
    logic  we;
    logic [DW-1:0] wd;
    #2;
    if (!rsta_n) begin
      resp_q.delete();
      last_b = 1'b1;
    end
    e_agnt = 1'b0;
    e_bgnt = 1'b0;
    if (rsta_n) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      e_agnt = a_req;
      e_bgnt = b_req && !a_req;
`else
      if (a_req && b_req) begin
        e_agnt = last_b;
        e_bgnt = !last_b;
      end else begin
        e_agnt = a_req;
        e_bgnt = b_req;
      end
`endif
    end
    e_arv  = 1'b0;
    e_brv  = 1'b0;
    e_data = '0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      e_arv  = !r.is_b;
      e_brv  = r.is_b;
      e_data = r.data;
    end
    e_ena  = rsta_n && prev_gnt;
    e_rsta = rsta_n && (rel_cnt == 0);
    o_agnt = a_gnt;  o_bgnt = b_gnt;  o_arv = a_rvalid;  o_brv = b_rvalid;
    o_ardata = a_rdata;  o_brdata = b_rdata;  o_ena = ram_ena;  o_wea = ram_wea;
    o_regce = ram_regcea;  o_rsta = ram_rsta;  o_addr = ram_addra;  o_din = ram_dina;
    if (e_agnt || e_bgnt) begin
      we = e_agnt ? a_we : b_we;
      ad = int'(e_agnt ? a_addr : b_addr);
      wd = e_agnt ? a_wdata : b_wdata;
      if (we) begin
        shadow[ad] = wd;
      end else begin
        r.is_b = e_bgnt;
        r.data = shadow.exists(ad) ? shadow[ad] : '0;
        r.due  = cyc + 1 + int'(RDL);
        resp_q.push_back(r);
      end
      last_b = e_bgnt;
    end
    prev_gnt = e_agnt || e_bgnt;
    rel_cnt  = rsta_n ? rel_cnt + 1 : 0;
    @(posedge clka);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rsta_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h001; a_wdata = 18'h1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h002; b_wdata = 18'h2;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({o_agnt, o_bgnt} !== 2'b00)
        $display("FAIL reset_gnt i=%0d got %b%b want 00", i, o_agnt, o_bgnt); else n_pass++;
      n_chk++; if ({o_ena, o_wea, o_regce, o_rsta, o_arv, o_brv} !== 6'b0 || o_addr !== '0 ||
                   o_din !== '0 || o_ardata !== '0 || o_brdata !== '0)
        $display("FAIL reset_ctrl i=%0d got ena=%b wea=%b regce=%b rsta=%b addr=%h din=%h",
                 i, o_ena, o_wea, o_regce, o_rsta, o_addr, o_din); else n_pass++;
    end
    rsta_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) a_req = 1'b0;
      if (i == 2) b_req = 1'b0;
      tick();
      n_chk++; if (o_agnt !== e_agnt || o_bgnt !== e_bgnt)
        $display("FAIL rel_gnt i=%0d got a=%b b=%b want a=%b b=%b", i, o_agnt, o_bgnt,
                 e_agnt, e_bgnt); else n_pass++;
      n_chk++; if (o_rsta !== e_rsta || o_rsta !== (i == 0))
        $display("FAIL rel_rsta i=%0d got %b want %b", i, o_rsta, e_rsta); else n_pass++;
      n_chk++; if (o_arv !== e_arv || o_brv !== e_brv || o_ena !== e_ena)
        $display("FAIL rel_rv i=%0d got a=%b b=%b ena=%b want a=%b b=%b ena=%b", i, o_arv,
                 o_brv, o_ena, e_arv, e_brv, e_ena); else n_pass++;
      if (i == 0) begin
        n_chk++; if (o_agnt !== 1'b1 || o_bgnt !== 1'b0)
          $display("FAIL rel_first_a got a=%b b=%b want a=1 b=0", o_agnt, o_bgnt); else n_pass++;
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 7; i++) begin
      a_req = (i < 2); a_we = (i == 0); a_addr = 10'h003; a_wdata = 18'h2A5A5;
      b_req = 1'b0;
      tick();
      n_chk++; if (o_agnt !== e_agnt || o_bgnt !== e_bgnt || o_ena !== e_ena)
        $display("FAIL wr_gnt i=%0d got a=%b b=%b ena=%b want a=%b b=%b ena=%b", i, o_agnt,
                 o_bgnt, o_ena, e_agnt, e_bgnt, e_ena); else n_pass++;
      n_chk++; if (o_arv !== (i == 4) || o_brv !== 1'b0 || o_arv !== e_arv)
        $display("FAIL wr_rvalid i=%0d got a=%b b=%b want a=%b b=0", i, o_arv, o_brv,
                 e_arv); else n_pass++;
      if (e_arv) begin
        n_chk++; if (o_ardata !== 18'h2A5A5 || o_ardata !== e_data)
          $display("FAIL wr_rdata got %h want %h", o_ardata, e_data); else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 12; i++) begin
      a_req = 1'b0; b_req = 1'b0;
      if (i == 0) begin a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_wdata = 18'h00111; end
      if (i == 1) begin b_req = 1'b1; b_we = 1'b1; b_addr = 10'h020; b_wdata = 18'h00222; end
      if (i >= 2 && i < 8) begin
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020;
      end
      tick();
      n_chk++; if (o_agnt !== e_agnt || o_bgnt !== e_bgnt)
        $display("FAIL rr_gnt i=%0d got a=%b b=%b want a=%b b=%b", i, o_agnt, o_bgnt,
                 e_agnt, e_bgnt); else n_pass++;
      n_chk++; if (o_arv !== e_arv || o_brv !== e_brv)
        $display("FAIL rr_rvalid i=%0d got a=%b b=%b want a=%b b=%b", i, o_arv, o_brv,
                 e_arv, e_brv); else n_pass++;
      if (e_arv || e_brv) begin
        n_chk++; if ((e_arv ? o_ardata : o_brdata) !== e_data)
          $display("FAIL rr_rdata i=%0d got a=%h b=%h want %h", i, o_ardata, o_brdata,
                   e_data); else n_pass++;
      end
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      if (i >= 2 && i < 8) begin
        n_chk++; if (o_agnt !== ((i % 2) == 0) || o_bgnt !== ((i % 2) == 1))
          $display("FAIL rr_alt i=%0d got a=%b b=%b", i, o_agnt, o_bgnt); else n_pass++;
      end
      if (i >= 5 && i <= 10) begin
        n_chk++; if ((i % 2) == 1 ? (o_arv !== 1'b1 || o_brv !== 1'b0 || o_ardata !== 18'h00111)
                                  : (o_brv !== 1'b1 || o_arv !== 1'b0 || o_brdata !== 18'h00222))
          $display("FAIL rr_resp i=%0d got a=%b/%h b=%b/%h", i, o_arv, o_ardata, o_brv,
                   o_brdata); else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      a_req = 1'b0;
      b_req = (i < 3); b_we = (i == 0); b_wdata = 18'h3FFFF;
      b_addr = (i == 2) ? 10'h000 : 10'h3FF;
      tick();
      n_chk++; if (o_agnt !== e_agnt || o_bgnt !== e_bgnt || o_ena !== e_ena)
        $display("FAIL b2b_gnt i=%0d got a=%b b=%b ena=%b want a=%b b=%b ena=%b", i, o_agnt,
                 o_bgnt, o_ena, e_agnt, e_bgnt, e_ena); else n_pass++;
      n_chk++; if (o_ena !== (i >= 1 && i <= 3))
        $display("FAIL b2b_ena i=%0d got %b", i, o_ena); else n_pass++;
      n_chk++; if (o_brv !== (i == 4 || i == 5) || o_arv !== 1'b0 || o_brv !== e_brv)
        $display("FAIL b2b_rvalid i=%0d got a=%b b=%b want b=%b", i, o_arv, o_brv,
                 e_brv); else n_pass++;
      if (e_brv) begin
        n_chk++; if (o_brdata !== e_data || o_brdata !== ((i == 4) ? 18'h3FFFF : 18'h00000))
          $display("FAIL b2b_rdata i=%0d got %h want %h", i, o_brdata, e_data); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 8; i++) begin
      b_req = 1'b0;
      a_req = (i == 0); a_we = 1'b0; a_addr = 10'h010;
      rsta_n = (i != 1);
      tick();
      n_chk++; if (o_agnt !== e_agnt || o_bgnt !== e_bgnt || o_rsta !== e_rsta)
        $display("FAIL mid_gnt i=%0d got a=%b b=%b rsta=%b want a=%b b=%b rsta=%b", i,
                 o_agnt, o_bgnt, o_rsta, e_agnt, e_bgnt, e_rsta); else n_pass++;
      n_chk++; if (o_arv !== 1'b0 || o_brv !== 1'b0 || o_arv !== e_arv)
        $display("FAIL mid_rvalid i=%0d got a=%b b=%b want 0", i, o_arv, o_brv); else n_pass++;
    end
  endtask

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    for (int i = 0; i < 9; i++) begin
      a_req = (i < 4); a_we = 1'b0; a_addr = 10'h010;
      b_req = (i < 5); b_we = 1'b0; b_addr = 10'h020;
      tick();
      n_chk++; if (o_agnt !== (i < 4) || o_bgnt !== (i == 4) || o_agnt !== e_agnt)
        $display("FAIL fp_gnt i=%0d got a=%b b=%b", i, o_agnt, o_bgnt); else n_pass++;
      n_chk++; if (o_arv !== e_arv || o_brv !== e_brv)
        $display("FAIL fp_rvalid i=%0d got a=%b b=%b want a=%b b=%b", i, o_arv, o_brv,
                 e_arv, e_brv); else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    bit a_pend = 1'b0;
    bit b_pend = 1'b0;
    for (int i = 0; i < 306; i++) begin
      if (i < 300 && !a_pend && $urandom_range(1, 0) == 1) begin
        a_pend = 1'b1; a_we = 1'($urandom_range(1, 0));
        a_addr = AW'(32'h100 + $urandom_range(15, 0)); a_wdata = DW'($urandom);
      end
      if (i < 300 && !b_pend && $urandom_range(1, 0) == 1) begin
        b_pend = 1'b1; b_we = 1'($urandom_range(1, 0));
        b_addr = AW'(32'h100 + $urandom_range(15, 0)); b_wdata = DW'($urandom);
      end
      a_req = a_pend;
      b_req = b_pend;
      tick();
      n_chk++; if (o_agnt !== e_agnt || o_bgnt !== e_bgnt || o_ena !== e_ena)
        $display("FAIL rnd_gnt i=%0d got a=%b b=%b ena=%b want a=%b b=%b ena=%b", i, o_agnt,
                 o_bgnt, o_ena, e_agnt, e_bgnt, e_ena); else n_pass++;
      n_chk++; if (o_arv !== e_arv || o_brv !== e_brv)
        $display("FAIL rnd_rvalid i=%0d got a=%b b=%b want a=%b b=%b", i, o_arv, o_brv,
                 e_arv, e_brv); else n_pass++;
      if (e_arv || e_brv) begin
        n_chk++; if ((e_arv ? o_ardata : o_brdata) !== e_data)
          $display("FAIL rnd_rdata i=%0d got a=%h b=%h want %h", i, o_ardata, o_brdata,
                   e_data); else n_pass++;
      end
      if (e_agnt) a_pend = 1'b0;
      if (e_bgnt) b_pend = 1'b0;
    end
  endtask

  initial begin
    rsta_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_reset_midflight();
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port no-change block RAM in the speckle sensor controller. It shares the one RAM port between the capture path (port A: sensor pixel writes and readback) and the host/readout path (port B). It grants at most one access per cycle, drives the RAM control pins, and returns read data to the granted requester with a fixed, tagged latency.

## Interface
Parameters:
- ADDR_W, 10, RAM address width (matches the RAM's address bus for depth 1024)
- DATA_W, 18, RAM data width
- RD_LATENCY, 2, RAM read latency in cycles: 2 for the registered-output RAM, 1 for the unregistered one; only 1 or 2 are legal

Ports:
- clka  in  1  clock, shared with the RAM
- rsta_n  in  1  asynchronous active-low reset
- a_req, b_req  in  1  access request, held until granted
- a_we, b_we  in  1  1 = write, 0 = read; qualified by req
- a_addr, b_addr  in  ADDR_W  access address
- a_wdata, b_wdata  in  DATA_W  write data
- a_gnt, b_gnt  out  1  combinational grant; the access is accepted in the cycle where req & gnt
- a_rvalid, b_rvalid  out  1  one-cycle pulse: read data valid for that port
- a_rdata, b_rdata  out  DATA_W  read data, valid only while rvalid is high
- ram_ena, ram_wea  out  1  registered RAM enable and write enable
- ram_addra  out  ADDR_W  registered RAM address
- ram_dina  out  DATA_W  registered RAM write data
- ram_regcea  out  1  RAM output-register enable
- ram_rsta  out  1  RAM output reset
- ram_douta  in  DATA_W  RAM output data

## Operation
- Arbitration happens in the cycle the request is presented, with one grant per cycle at most.
  - If only one port requests, that port is granted.
  - If both request, the port not granted most recently wins (round-robin).
  - The last-winner flag resets to B, so A wins the first conflict.
- Granted command registration: at the next edge the arbiter registers ram_ena=1, ram_wea=we, ram_addra, and ram_dina.
  - With no grant, ram_ena=0.
  - The other fields hold their previous values.
- Read tracking: every granted read pushes an owner tag (A/B) into a shift pipeline of depth 1+RD_LATENCY. Writes and idle cycles push "none".
- ram_regcea is high exactly in the cycle the RAM's internal read register holds a tracked read (RD_LATENCY=2 only); otherwise it is 0.
- When a tag exits the pipeline:
  - The owning port gets rvalid=1 and rdata=ram_douta.
  - The other port's rvalid stays 0.
  - Both rdata buses carry ram_douta; consumers must qualify with rvalid.
- Ordering: read responses return in grant order, with no reordering and no stalls. Requesters must always accept rvalid.
- ram_rsta is high for exactly the first cycle after rsta_n deasserts, which clears the RAM output register. It is 0 otherwise.
- Write-then-read to the same address in consecutive grants returns the new data, because the RAM write commits before the following read.

## Timing
- Reset values: a_gnt, b_gnt = 0 (forced while rsta_n low). a_rvalid, b_rvalid, ram_ena, ram_wea, ram_regcea = 0. ram_addra, ram_dina, a_rdata, b_rdata = 0. ram_rsta = 0 during reset.
- Read grant in cycle N:
  - RAM command is active in N+1.
  - rvalid is seen in cycle N+1+RD_LATENCY, i.e. N+3 by default.
- Throughput: one access per cycle sustained, with reads and writes freely interleaved.
- Reset mid-operation: all in-flight tags are discarded, so no rvalid fires for reads granted before reset. RAM contents are untouched.
- A request that is not granted holds its fields stable. The arbiter does not latch ungranted requests.

## Configuration
- RAM_ARB_FIXED_PRIORITY_EN:
  - Defined: port A always wins a conflict. Port B is granted only when a_req=0, and the round-robin flag is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold rsta_n=0 with both req=1, then release. Required: gnt=0 and all RAM controls 0 during reset; ram_rsta=1 in the first cycle after release only; A granted first on the conflict.
- Single write then read: A writes 0x2A5A5 to addr 0x003, then A reads 0x003 on the next cycle. Required: a_rvalid exactly 3 cycles after the read grant with a_rdata=0x2A5A5; b_rvalid stays 0.
- Round-robin: both ports request reads continuously (A addr 0x010, B addr 0x020, preloaded 0x00111 and 0x00222). Required: grants alternate A,B,A,B, and rvalid alternates with the matching data 3 cycles later.
- Back-to-back mixed traffic: B issues write 0x3FFFF@0x3FF, read 0x3FF, read 0x000 on consecutive cycles. Required: ram_ena high for 3 consecutive cycles, then b_rvalid on 2 consecutive cycles with 0x3FFFF then 0x00000.
- Reset mid-flight: A reads 0x010, and rsta_n pulses low 1 cycle after the grant. Required: no a_rvalid is ever produced for that read.
- Fixed priority build with RAM_ARB_FIXED_PRIORITY_EN defined: both request for 4 cycles. Required: a_gnt=1 all 4 cycles and b_gnt=0; B is granted in the first cycle a_req drops.
